stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Run/pause/clear sequencer for the stopwatch timebase. It converts single-cycle button pulses into a 4-state control FSM. It also generates the count-enable and display-scan timing as single-cycle enables on the one system clock, replacing derived clocks. It sits between the button debouncers and the BCD digit counters / seven-segment scan mux.

Parameters:
CNT_DIV, 4, clk cycles per cnt_en pulse (sim value; 100000 for 1 ms at 100 MHz); legal range >= 2
SCAN_DIV, 4, clk cycles per scan_en pulse (sim value; 25000 for hardware); legal range >= 2
- Internal prescaler widths are $clog2(CNT_DIV) and $clog2(SCAN_DIV). No other width parameters.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
start_stop  input  1  single-cycle pulse, toggles run/pause
clear  input  1  single-cycle pulse, return to idle and zero digits
tc_in  input  1  high while digit counters hold their maximum value
cnt_en  output  1  one-cycle advance strobe to digit counters
cnt_clr  output  1  one-cycle synchronous clear strobe to digit counters
scan_en  output  1  one-cycle strobe to display scan mux
digit_sel  output  2  active digit index for the anode mux
running  output  1  high when state == RUN
state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, SAT=11

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-high. While reset is high:
  - state=IDLE; both prescalers=0.
  - cnt_en=0, cnt_clr=0, scan_en=0, digit_sel=0, running=0.
- All outputs are registered. No combinational path from any input to any output.
- Priority when multiple events share a cycle: clear > start_stop > terminal count.
- FSM, evaluated per clk edge:
  - IDLE: start_stop -> RUN, count prescaler forced to 0. clear -> stay in IDLE, pulse cnt_clr.
  - RUN: clear -> IDLE. start_stop -> PAUSE. Otherwise, a prescaler wrap while tc_in=1 -> SAT, and the cnt_en for that wrap is suppressed.
  - PAUSE: start_stop -> RUN, prescaler resumes from its held value (not cleared). clear -> IDLE.
  - SAT: start_stop ignored. clear -> IDLE.
- cnt_clr:
  - Asserted for exactly one cycle, the cycle after clear is sampled, in every state.
  - The count prescaler is zeroed on that same edge.
- Count prescaler (cp):
  - Increments only in RUN and holds in PAUSE/SAT/IDLE.
  - When cp==CNT_DIV-1 in RUN, it wraps to 0 and cnt_en is registered high for the next cycle (unless suppressed by tc_in).
  - First cnt_en after IDLE->RUN: high in the cycle after edge k+CNT_DIV, where edge k sampled start_stop.
  - A start_stop arriving on the wrap edge takes priority: no cnt_en, cp holds CNT_DIV-1, and the pulse is issued on the first RUN cycle after resume.
- cnt_en is never high in IDLE, PAUSE or SAT. Maximum rate is 1 per CNT_DIV cycles.
- Scan prescaler:
  - Free-running in all states, reset only by reset.
  - scan_en is high for one cycle every SCAN_DIV cycles.
  - digit_sel increments modulo 4 on the same edge that sets scan_en, so 3 wraps to 0.
  - First scan_en: the cycle after the SCAN_DIV-th edge following reset release.
- running is a registered decode of the next state, so it changes on the same edge as state.
- Reset mid-operation (any state, any prescaler value) returns to the reset values immediately. There is no cnt_clr pulse on reset; digit counters take reset directly.
- tc_in is sampled only on RUN wrap edges.

Test Plan:
1. Start and count (CNT_DIV=4): reset, then start_stop at edge 10 -> state=01 from edge 10; cnt_en high after edges 14, 18, 22; 3 pulses in 12 cycles.
2. Pause and resume: pause at cp=2 for 7 cycles, then resume -> no cnt_en while paused; next cnt_en exactly 2 RUN cycles after resume, then every 4 cycles.
3. Clear/start collision: clear and start_stop in the same cycle while in RUN -> state=00, a single cnt_clr pulse, cp=0, no cnt_en afterwards.
4. Saturation: tc_in=1 before a wrap -> state=11 on the wrap edge and no cnt_en. Then start_stop -> still 11. Then clear -> 00 with a cnt_clr pulse.
5. Scan (SCAN_DIV=4): 20 cycles from reset -> scan_en after edges 4, 8, 12, 16, 20; digit_sel sequence 1, 2, 3, 0, 1; unaffected by FSM activity.
6. Async reset mid-RUN with cp=3 -> all outputs 0 immediately, without waiting for a clk edge. After release, the count resumes only on a new start_stop.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the stopwatch timebase.
// Produces single-cycle count and scan enables on the system clock.
module stopwatch_ctrl #(
  parameter int CNT_DIV  = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       tc_in,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       scan_en,
  output logic [1:0] digit_sel,
  output logic       running,
  output logic [1:0] state
);

  localparam int CP_W = $clog2(CNT_DIV);
  localparam int SP_W = $clog2(SCAN_DIV);
  localparam logic [CP_W-1:0] CP_MAX = CP_W'(CNT_DIV - 1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    SAT   = 2'b11
  } state_t;

  state_t          fsm;
  logic [CP_W-1:0] cp;
  logic [SP_W-1:0] sp;

  assign state = fsm;

  // Clear outranks start_stop, which outranks a terminal-count wrap.
  // A start_stop on the wrap edge leaves cp at its maximum so the pulse
  // is issued on the first RUN edge after resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm     <= IDLE;
      cp      <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= clear;
      if (clear) begin
        fsm     <= IDLE;
        cp      <= '0;
        running <= 1'b0;
      end else begin
        case (fsm)
          IDLE: begin
            if (start_stop) begin
              fsm     <= RUN;
              cp      <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (start_stop) begin
              fsm     <= PAUSE;
              running <= 1'b0;
            end else if (cp == CP_MAX) begin
              cp <= '0;
              if (tc_in) begin
                fsm     <= SAT;
                running <= 1'b0;
              end else begin
                cnt_en <= 1'b1;
              end
            end else begin
              cp <= cp + CP_W'(1);
            end
          end
          PAUSE: begin
            if (start_stop) begin
              fsm     <= RUN;
              running <= 1'b1;
            end
          end
          SAT: begin
            fsm <= SAT;
          end
          default: begin
            fsm     <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  // Scan timebase runs regardless of FSM state; only reset restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      scan_en   <= 1'b0;
      digit_sel <= 2'd0;
    end else if (sp == SP_MAX) begin
      sp        <= '0;
      scan_en   <= 1'b1;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      sp      <= sp + SP_W'(1);
      scan_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with CNT_DIV=4, SCAN_DIV=4.
// Edge numbers count rising clk edges since the most recent reset release.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       reset;
  logic       start_stop;
  logic       clear;
  logic       tc_in;
  logic       cnt_en;
  logic       cnt_clr;
  logic       scan_en;
  logic [1:0] digit_sel;
  logic       running;
  logic [1:0] state;

  int checks;
  int passes;
  int n;
  int pulses;

  stopwatch_ctrl #(.CNT_DIV(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .tc_in     (tc_in),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .scan_en   (scan_en),
    .digit_sel (digit_sel),
    .running   (running),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", tag, got, exp, $time, n);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic ss, input logic clr, input logic tc);
    start_stop = ss;
    clear      = clr;
    tc_in      = tc;
  endtask

  // Advance one edge, then check the free-running scan timebase.
  task automatic step();
    @(posedge clk);
    n++;
    #1;
    checkOutput("scan_en", 32'(scan_en), 32'((n % 4) == 0));
    checkOutput("digit_sel", 32'(digit_sel), 32'((n / 4) % 4));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"},     32'(state),     32'd0);
    checkOutput({tag, "_running"},   32'(running),   32'd0);
    checkOutput({tag, "_cnt_en"},    32'(cnt_en),    32'd0);
    checkOutput({tag, "_cnt_clr"},   32'(cnt_clr),   32'd0);
    checkOutput({tag, "_scan_en"},   32'(scan_en),   32'd0);
    checkOutput({tag, "_digit_sel"}, 32'(digit_sel), 32'd0);
  endtask

  // Hand-derived state trace for the first session (edges 1..67).
  function automatic logic [1:0] expState(input int e);
    if (e < 10)       return 2'b00;
    else if (e <= 24) return 2'b01;
    else if (e <= 31) return 2'b10;
    else if (e <= 43) return 2'b01;
    else if (e <= 52) return 2'b00;
    else if (e <= 56) return 2'b01;
    else if (e <= 61) return 2'b11;
    else if (e <= 63) return 2'b00;
    else              return 2'b01;
  endfunction

  initial begin
    logic ss, clr, tc;
    logic [1:0] es;
    checks = 0;
    passes = 0;
    n      = 0;
    pulses = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    #3;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    checkAllZero("reset_edge");
    reset = 1'b0;
    n     = 0;

    // Session 1: start, pause/resume, clear+start collision, saturation.
    for (int e = 1; e <= 67; e++) begin
      step();
      ss  = (e + 1 == 10) || (e + 1 == 25) || (e + 1 == 32) || (e + 1 == 44) ||
            (e + 1 == 53) || (e + 1 == 60) || (e + 1 == 64);
      clr = (e + 1 == 44) || (e + 1 == 48) || (e + 1 == 62);
      tc  = (e + 1 == 56) || (e + 1 == 57);
      applyStimulus(ss, clr, tc);
      es = expState(e);
      checkOutput("state", 32'(state), 32'(es));
      checkOutput("running", 32'(running), 32'(es == 2'b01));
      checkOutput("cnt_en", 32'(cnt_en),
                  32'(e == 14 || e == 18 || e == 22 || e == 34 || e == 38 || e == 42));
      checkOutput("cnt_clr", 32'(cnt_clr), 32'(e == 44 || e == 48 || e == 62));
      if (e >= 11 && e <= 22 && cnt_en) pulses++;
    end
    checkOutput("start_pulses", 32'(pulses), 32'd3);

    // Asynchronous reset mid-RUN (cp=3), well away from any clk edge.
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #1;
    checkAllZero("async_reset_edge");
    reset = 1'b0;
    n     = 0;

    // Session 2: no counting until a fresh start_stop at edge 9.
    for (int e = 1; e <= 13; e++) begin
      step();
      applyStimulus(e + 1 == 9, 1'b0, 1'b0);
      checkOutput("s2_state", 32'(state), (e >= 9) ? 32'd1 : 32'd0);
      checkOutput("s2_running", 32'(running), 32'(e >= 9));
      checkOutput("s2_cnt_en", 32'(cnt_en), 32'(e == 13));
      checkOutput("s2_cnt_clr", 32'(cnt_clr), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
